race_referee: RTL
=================

# race_referee

Tracks each player's progress around the track and decides when the race is over. It samples both cars' world coordinates (320x240 map space) and checks them against one finish zone and three checkpoint zones. It counts checkpoints and laps, reports per-player checkpoint counts for the HUD flag display, and raises `is_game_end` to the game state FSM when the first player completes `LAPS` laps.

## Interface
Parameters:
- `LAPS`, default 3: laps needed to finish, range 1..3.
- `ZONE0`, default {10'd5,10'd40,10'd130,10'd140}: finish zone, packed {x0,x1,y0,y1}, all bounds inclusive.
- `ZONE1`, default {10'd140,10'd180,10'd5,10'd40}: checkpoint 1.
- `ZONE2`, default {10'd280,10'd315,10'd100,10'd140}: checkpoint 2.
- `ZONE3`, default {10'd140,10'd180,10'd200,10'd235}: checkpoint 3.
- `TICK_DIV`, default 1000000: `clk` cycles per centisecond. Used only with the timer option.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset. Asynchronous, active-low.
- `state`  in  3  game FSM state: IDLE=0, SETTING=1, COUNTDOWN=3, RACING=4, PAUSE=5, FINISH=6.
- `p1_x`, `p1_y`  in  10 each  P1 world position.
- `p2_x`, `p2_y`  in  10 each  P2 world position.
- `p1_flag`, `p2_flag`  out  2 each  checkpoints cleared in the current lap (0..3).
- `p1_lap`, `p2_lap`  out  2 each  completed laps.
- `winner`  out  2  0=none, 1=P1, 2=P2, 3=tie.
- `is_game_end`  out  1  level signal; high while in R_DONE.
- `race_time`  out  16  elapsed racing time in centiseconds.

## Operation
- Zone test: a player is inside zone k when x0<=x<=x1 and y0<=y<=y1, using unsigned 10-bit compares. There are 8 independent tests, 4 zones per player.
- `inside[p][k]` is registered every cycle in all states. `entry = inside & ~inside_d`, where `inside_d` is `inside` delayed by one cycle.
- Per-player progress register `nxt` (2 bits): 1, 2 or 3 means that checkpoint is awaited; 0 means the finish zone is awaited. `flag` equals `nxt-1` when `nxt` is nonzero, and 3 when `nxt` is 0.
- An entry into zone `nxt` while `nxt` is nonzero increments `nxt`, wrapping 3 to 0.
- An entry into ZONE0 while `nxt`=0 increments `lap` and sets `nxt` to 1.
- Entries into any other zone are ignored. Wrong-way and out-of-order passes therefore never count.
- A player is finished when its `lap` reaches `LAPS`. `lap` never exceeds `LAPS`.
- Referee FSM:
  - R_CLEAR: `nxt`=1, laps=0, winner=0, timer=0. Go to R_RUN when `state`=RACING.
  - R_RUN: progress updates are applied. Go to R_HOLD on `state`=PAUSE. Go to R_DONE on the first finish.
  - R_HOLD: no progress updates. Entries that occur here are discarded and are not replayed on resume. Go to R_RUN when `state`=RACING.
  - R_DONE: all progress frozen and `is_game_end`=1.
- From any referee state, go to R_CLEAR when `state` is IDLE, SETTING, COUNTDOWN, 2 or 7.
- In R_RUN, `state`=FINISH behaves like R_HOLD. In R_DONE, `state`=FINISH stays in R_DONE.
- Winner decision: if both players finish on the same edge, `winner`=3. Otherwise the first player to finish is the winner. `winner` is latched on entry to R_DONE.
- Reset values: all outputs 0, internal `nxt`=1, FSM in R_CLEAR, `inside_d`=0.
- Reset mid-race clears all progress immediately. A car sitting inside a zone when reset releases does not produce an entry, because `inside` and `inside_d` both refill with the same value.

## Timing
- A coordinate change at the inputs before edge t is registered into `inside` at edge t. `entry` is valid during cycle t+1. `nxt`, `lap` and `flag` update at edge t+1.
- On the finishing entry, `is_game_end` and `winner` update at the same edge t+1 as `lap`. The state FSM sees `is_game_end` one cycle later.
- FSM transitions taken on a `state` change occur at the next edge.
- At most one progress step per player per cycle. Zones may overlap; only the awaited zone acts.

## Configuration
- `RACE_TIMER_EN` defined:
  - A prescaler counts to `TICK_DIV-1` and advances only in R_RUN.
  - Each wrap increments `race_time`, which saturates at 65535.
  - `race_time` and the prescaler freeze in R_HOLD and R_DONE and clear in R_CLEAR.
- `RACE_TIMER_EN` undefined: no prescaler is built and `race_time` is constant 0.

## Test plan
- **Normal race.** LAPS=1; state 3 then 4; drive P1 through ZONE1, ZONE2, ZONE3, then ZONE0. Required: `p1_flag` steps 1, 2, 3; `p1_lap`=1; `winner`=1; `is_game_end`=1, two edges after the ZONE0 coordinate.
- **Out-of-order pass.** P2 enters ZONE2 first, then ZONE0. Required: `p2_flag` stays 0 and `p2_lap` stays 0.
- **Pause mid-race.** state=5; P1 enters ZONE1; state back to 4 with P1 still inside. Required: `p1_flag` stays 0. Then leave and re-enter ZONE1: `p1_flag`=1.
- **Tie.** Both cars enter ZONE0 on the same cycle with `nxt`=0 and lap=LAPS-1. Required: `winner`=3 and `is_game_end`=1.
- **Reset and return to IDLE.** Assert `rst`=0 mid-race: all outputs 0 immediately. Separately, state 6 then 0 from R_DONE: outputs clear on the next edge.
- **Timer (with RACE_TIMER_EN).** TICK_DIV=4; 40 RACING cycles give `race_time`=10; 20 PAUSE cycles leave it at 10.

Source files
------------

// File: rtl/race_referee.sv
// race_referee: per-player checkpoint/lap tracking and race-end decision for two cars.
// Latency: a coordinate is registered into the zone flags at edge t, and progress/winner/end update at edge t+1.
// Optional feature macro RACE_TIMER_EN builds the centisecond race timer; otherwise race_time is tied to 0.
module race_referee #(
  parameter int          LAPS     = 3,
  parameter logic [39:0] ZONE0    = {10'd5,   10'd40,  10'd130, 10'd140},
  parameter logic [39:0] ZONE1    = {10'd140, 10'd180, 10'd5,   10'd40},
  parameter logic [39:0] ZONE2    = {10'd280, 10'd315, 10'd100, 10'd140},
  parameter logic [39:0] ZONE3    = {10'd140, 10'd180, 10'd200, 10'd235},
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  state,
  input  logic [9:0]  p1_x,
  input  logic [9:0]  p1_y,
  input  logic [9:0]  p2_x,
  input  logic [9:0]  p2_y,
  output logic [1:0]  p1_flag,
  output logic [1:0]  p2_flag,
  output logic [1:0]  p1_lap,
  output logic [1:0]  p2_lap,
  output logic [1:0]  winner,
  output logic        is_game_end,
  output logic [15:0] race_time
);

  localparam logic [1:0] LAPS_L = 2'(LAPS);

  typedef enum logic [1:0] {R_CLEAR, R_RUN, R_HOLD, R_DONE} ref_state_t;

  ref_state_t fsm_q, fsm_d;
  logic [7:0] zone_now;        // [3:0] P1 zones 0..3, [7:4] P2 zones 0..3
  logic [7:0] inside_q;
  logic [7:0] inside_prev_q;
  logic       armed_q;
  logic [7:0] entry;
  logic [1:0] nxt1_q, nxt1_d, nxt2_q, nxt2_d;
  logic [1:0] lap1_q, lap1_d, lap2_q, lap2_d;
  logic [1:0] winner_q, winner_d;
  logic [3:0] adv1, adv2;
  logic       fin1, fin2;
  logic       clr_req, go_race, go_hold;

  // Inclusive rectangle test on packed {x0,x1,y0,y1}.
  function automatic logic in_zone(input logic [9:0] x, input logic [9:0] y, input logic [39:0] z);
    return (x >= z[39:30]) && (x <= z[29:20]) && (y >= z[19:10]) && (y <= z[9:0]);
  endfunction

  // One progress step: advance to the next checkpoint, or close a lap at the finish zone.
  // Returns {nxt, lap}.
  function automatic logic [3:0] advance(input logic [1:0] nxt, input logic [1:0] lap,
                                         input logic [3:0] ent);
    logic [1:0] n;
    logic [1:0] l;
    n = nxt;
    l = lap;
    if (nxt != 2'd0) begin
      if (ent[nxt]) n = nxt + 2'd1;          // 3 wraps to 0: finish zone awaited
    end else if (ent[0] && (lap != LAPS_L)) begin
      l = lap + 2'd1;
      n = 2'd1;
    end
    return {n, l};
  endfunction

  // All eight zone tests on the live coordinates.
  always_comb begin
    zone_now = {in_zone(p2_x, p2_y, ZONE3), in_zone(p2_x, p2_y, ZONE2),
                in_zone(p2_x, p2_y, ZONE1), in_zone(p2_x, p2_y, ZONE0),
                in_zone(p1_x, p1_y, ZONE3), in_zone(p1_x, p1_y, ZONE2),
                in_zone(p1_x, p1_y, ZONE1), in_zone(p1_x, p1_y, ZONE0)};
  end

  // Zone flags and their one-cycle delay; on the first edge after reset both load the
  // same value so a car already parked in a zone does not produce an entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inside_q      <= '0;
      inside_prev_q <= '0;
      armed_q       <= 1'b0;
    end else begin
      inside_q      <= zone_now;
      inside_prev_q <= armed_q ? inside_q : zone_now;
      armed_q       <= 1'b1;
    end
  end

  assign entry   = inside_q & ~inside_prev_q;
  assign adv1    = advance(nxt1_q, lap1_q, entry[3:0]);
  assign adv2    = advance(nxt2_q, lap2_q, entry[7:4]);
  assign fin1    = (adv1[1:0] == LAPS_L);
  assign fin2    = (adv2[1:0] == LAPS_L);
  assign go_race = (state == 3'd4);
  assign go_hold = (state == 3'd5) || (state == 3'd6);
  assign clr_req = !(go_race || go_hold);

  // Referee FSM next state plus progress and winner next values.
  always_comb begin
    fsm_d    = fsm_q;
    nxt1_d   = nxt1_q;
    nxt2_d   = nxt2_q;
    lap1_d   = lap1_q;
    lap2_d   = lap2_q;
    winner_d = winner_q;
    if (clr_req) begin
      fsm_d    = R_CLEAR;
      nxt1_d   = 2'd1;
      nxt2_d   = 2'd1;
      lap1_d   = 2'd0;
      lap2_d   = 2'd0;
      winner_d = 2'd0;
    end else begin
      unique case (fsm_q)
        R_CLEAR: if (go_race) fsm_d = R_RUN;
        R_RUN: begin
          {nxt1_d, lap1_d} = adv1;
          {nxt2_d, lap2_d} = adv2;
          if (fin1 || fin2) begin
            fsm_d    = R_DONE;
            winner_d = {fin2, fin1};          // 1=P1, 2=P2, 3=same-edge tie
          end else if (go_hold) begin
            fsm_d = R_HOLD;
          end
        end
        R_HOLD:  if (go_race) fsm_d = R_RUN;
        R_DONE:  fsm_d = R_DONE;
        default: fsm_d = R_CLEAR;
      endcase
    end
  end

  // Referee state, progress and winner registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q    <= R_CLEAR;
      nxt1_q   <= 2'd1;
      nxt2_q   <= 2'd1;
      lap1_q   <= 2'd0;
      lap2_q   <= 2'd0;
      winner_q <= 2'd0;
    end else begin
      fsm_q    <= fsm_d;
      nxt1_q   <= nxt1_d;
      nxt2_q   <= nxt2_d;
      lap1_q   <= lap1_d;
      lap2_q   <= lap2_d;
      winner_q <= winner_d;
    end
  end

  assign p1_flag     = (nxt1_q == 2'd0) ? 2'd3 : nxt1_q - 2'd1;
  assign p2_flag     = (nxt2_q == 2'd0) ? 2'd3 : nxt2_q - 2'd1;
  assign p1_lap      = lap1_q;
  assign p2_lap      = lap2_q;
  assign winner      = winner_q;
  assign is_game_end = (fsm_q == R_DONE);

`ifdef RACE_TIMER_EN
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   time_q, time_d;

  // Prescaler runs only while racing; each wrap adds one saturating centisecond.
  always_comb begin
    presc_d = presc_q;
    time_d  = time_q;
    if (clr_req) begin
      presc_d = '0;
      time_d  = '0;
    end else if (fsm_q == R_RUN) begin
      if (presc_q == PW'(TICK_DIV - 1)) begin
        presc_d = '0;
        if (time_q != 16'hFFFF) time_d = time_q + 16'd1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // Timer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      time_q  <= '0;
    end else begin
      presc_q <= presc_d;
      time_q  <= time_d;
    end
  end

  assign race_time = time_q;
`else
  // No timer built; TICK_DIV only has meaning when it is.
  assign race_time = (TICK_DIV > 0) ? 16'd0 : 16'd0;
`endif

endmodule
